// File: rtl/seg_pkg.sv
// Shared constants for the 4-line LED symbol code: legal patterns, decoded
// value width and the acceptance FSM states.
package seg_pkg;

  localparam int DEC_W = 2;

  localparam logic [3:0] PAT_0 = 4'b0000;
  localparam logic [3:0] PAT_1 = 4'b0011;
  localparam logic [3:0] PAT_2 = 4'b1001;
  localparam logic [3:0] PAT_3 = 4'b0110;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    EMIT   = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg_pat_decode.sv
// Combinational lookup of a 4-bit LED pattern into its symbol value and a
// legal flag; any pattern outside the four symbols reports legal = 0.
module seg_pat_decode
  import seg_pkg::*;
(
  input  logic [3:0]       pat_i,
  output logic [DEC_W-1:0] value_o,
  output logic             legal_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    value_o = '0;
    legal_o = 1'b0;
    unique case (pat_i)
      PAT_0:   begin value_o = 2'd0; legal_o = 1'b1; end
      PAT_1:   begin value_o = 2'd1; legal_o = 1'b1; end
      PAT_2:   begin value_o = 2'd2; legal_o = 1'b1; end
      PAT_3:   begin value_o = 2'd3; legal_o = 1'b1; end
      default: begin value_o = '0;   legal_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/seg_to_num.sv
// Debounces a 4-line LED symbol: a pattern must be sampled STABLE_CYCLES
// times in a row before it is decoded once into num (or flagged as err).
module seg_to_num
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             led4,
  input  logic             led3,
  input  logic             led2,
  input  logic             led1,
  input  logic             clr,
  output logic [31:0]      num,
  output logic             valid,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] sym_cnt
);

  localparam logic [7:0]       STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [3:0]       pat_q, prev_q;
  logic             pat_vld_q, prev_vld_q;
  logic [7:0]       stab_q, stab_d;
  state_t           state_q, state_d;
  logic [DEC_W-1:0] num_q, num_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEC_W-1:0] dec_value;
  logic             dec_legal;
  logic             same;

  seg_pat_decode u_decode (
    .pat_i   (pat_q),
    .value_o (dec_value),
    .legal_o (dec_legal)
  );

  // The reset value of pat_q is not a real sample, so it never counts as a match.
  assign same = prev_vld_q && (pat_q == prev_q);

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    num_d   = num_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      SETTLE: begin
        if (!same) begin
          stab_d = '0;
        end else if (stab_q + 8'd1 == STAB_LAST) begin
          state_d = EMIT;
          stab_d  = '0;
          if (dec_legal) begin
            num_d   = dec_value;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          stab_d = stab_q + 8'd1;
        end
      end
      EMIT: begin
        // A change already visible during the emit cycle must not be lost in HOLD.
        state_d = same ? HOLD : SETTLE;
        stab_d  = '0;
      end
      HOLD: begin
        if (!same) begin
          state_d = SETTLE;
          stab_d  = '0;
        end
      end
      default: begin
        state_d = SETTLE;
        stab_d  = '0;
      end
    endcase

    // Clear is applied before this cycle's events, so a coincident event survives.
    sticky_d = (clr ? 1'b0 : sticky_q) | err_d;
    cnt_d    = clr ? '0 : cnt_q;
    if (valid_d && cnt_d != CNT_MAX) begin
      cnt_d = cnt_d + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q      <= '0;
      prev_q     <= '0;
      pat_vld_q  <= 1'b0;
      prev_vld_q <= 1'b0;
      stab_q     <= '0;
      state_q    <= SETTLE;
      num_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pat_q      <= {led4, led3, led2, led1};
      prev_q     <= pat_q;
      pat_vld_q  <= 1'b1;
      prev_vld_q <= pat_vld_q;
      stab_q     <= stab_d;
      state_q    <= state_d;
      num_q      <= num_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign num        = {{(32 - DEC_W){1'b0}}, num_q};
  assign valid      = valid_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign sym_cnt    = cnt_q;

endmodule

// File: tb/tb_seg_to_num.sv
// Directed bench for seg_to_num: default instance (CNT_W=8) plus a CNT_W=2
// instance for counter saturation; expected values are hand-computed.
module tb_seg_to_num;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] pat_a = 4'b0000;
  logic [3:0] pat_b = 4'b0000;
  logic       clr_a = 1'b0;
  logic       clr_b = 1'b0;

  logic [31:0] num_a, num_b;
  logic        valid_a, valid_b, err_a, err_b, sticky_a, sticky_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int passes = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  seg_to_num #(.STABLE_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .led4(pat_a[3]), .led3(pat_a[2]), .led2(pat_a[1]), .led1(pat_a[0]),
    .clr(clr_a), .num(num_a), .valid(valid_a), .err(err_a),
    .err_sticky(sticky_a), .sym_cnt(cnt_a)
  );

  seg_to_num #(.STABLE_CYCLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .led4(pat_b[3]), .led3(pat_b[2]), .led2(pat_b[1]), .led1(pat_b[0]),
    .clr(clr_b), .num(num_b), .valid(valid_b), .err(err_b),
    .err_sticky(sticky_b), .sym_cnt(cnt_b)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pattern is driven first; reset edge r captures 0000, edge r+1 is the first real sample.
  task automatic reset_with(input logic [3:0] pa, input logic [3:0] pb);
    pat_a = pa;
    pat_b = pb;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Advances n edges; tick i=1 is the edge capturing the currently driven pattern.
  task automatic run(input bit sel, input int n, output int nv, output int ne,
                     output int fv, output int fe);
    logic v, e;
    nv = 0; ne = 0; fv = -1; fe = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      v = sel ? valid_b : valid_a;
      e = sel ? err_b : err_a;
      if (v && e) both_cnt++;
      if (v) begin nv++; if (fv < 0) fv = i; end
      if (e) begin ne++; if (fe < 0) fe = i; end
    end
  endtask

  task automatic test_reset();
    reset_with(4'b0101, 4'b0101);
    checks++; if (num_a !== 32'd0) $display("FAIL reset_num got %0d exp 0", num_a); else passes++;
    checks++; if (valid_a !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_a); else passes++;
    checks++; if (err_a !== 1'b0) $display("FAIL reset_err got %b exp 0", err_a); else passes++;
    checks++; if (sticky_a !== 1'b0) $display("FAIL reset_sticky got %b exp 0", sticky_a); else passes++;
    checks++; if (cnt_a !== 8'd0) $display("FAIL reset_cnt got %0d exp 0", cnt_a); else passes++;
    checks++; if (cnt_b !== 2'd0) $display("FAIL reset_cnt_b got %0d exp 0", cnt_b); else passes++;
  endtask

  task automatic test_single();
    int nv, ne, fv, fe;
    reset_with(4'b1001, 4'b0101);
    run(1'b0, 10, nv, ne, fv, fe);
    checks++; if (nv !== 1) $display("FAIL single_nvalid got %0d exp 1", nv); else passes++;
    checks++; if (fv !== 5) $display("FAIL single_latency got %0d exp 5", fv); else passes++;
    checks++; if (ne !== 0) $display("FAIL single_nerr got %0d exp 0", ne); else passes++;
    checks++; if (num_a !== 32'd2) $display("FAIL single_num got %0d exp 2", num_a); else passes++;
    checks++; if (cnt_a !== 8'd1) $display("FAIL single_cnt got %0d exp 1", cnt_a); else passes++;
  endtask

  task automatic test_glitch_then_illegal();
    int nv, ne, fv, fe;
    reset_with(4'b0011, 4'b0101);
    run(1'b0, 3, nv, ne, fv, fe);
    checks++; if (nv !== 0) $display("FAIL glitch_nvalid got %0d exp 0", nv); else passes++;
    pat_a = 4'b0110;
    run(1'b0, 8, nv, ne, fv, fe);
    checks++; if (nv !== 1) $display("FAIL switch_nvalid got %0d exp 1", nv); else passes++;
    checks++; if (fv !== 5) $display("FAIL switch_latency got %0d exp 5", fv); else passes++;
    checks++; if (num_a !== 32'd3) $display("FAIL switch_num got %0d exp 3", num_a); else passes++;
    checks++; if (cnt_a !== 8'd1) $display("FAIL switch_cnt got %0d exp 1", cnt_a); else passes++;
    // Illegal pattern from HOLD: error once, num and count unchanged.
    pat_a = 4'b1111;
    run(1'b0, 8, nv, ne, fv, fe);
    checks++; if (ne !== 1) $display("FAIL illegal_nerr got %0d exp 1", ne); else passes++;
    checks++; if (fe !== 5) $display("FAIL illegal_latency got %0d exp 5", fe); else passes++;
    checks++; if (nv !== 0) $display("FAIL illegal_nvalid got %0d exp 0", nv); else passes++;
    checks++; if (sticky_a !== 1'b1) $display("FAIL illegal_sticky got %b exp 1", sticky_a); else passes++;
    checks++; if (num_a !== 32'd3) $display("FAIL illegal_num got %0d exp 3", num_a); else passes++;
    checks++; if (cnt_a !== 8'd1) $display("FAIL illegal_cnt got %0d exp 1", cnt_a); else passes++;
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    checks++; if (sticky_a !== 1'b0) $display("FAIL clr_sticky got %b exp 0", sticky_a); else passes++;
    checks++; if (cnt_a !== 8'd0) $display("FAIL clr_cnt got %0d exp 0", cnt_a); else passes++;
  endtask

  task automatic test_clr_with_err();
    int nv, ne, fv, fe;
    reset_with(4'b1111, 4'b0101);
    run(1'b0, 4, nv, ne, fv, fe);
    checks++; if (ne !== 0) $display("FAIL pre_err_nerr got %0d exp 0", ne); else passes++;
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    checks++; if (err_a !== 1'b1) $display("FAIL clr_err_pulse got %b exp 1", err_a); else passes++;
    checks++; if (sticky_a !== 1'b1) $display("FAIL clr_err_sticky got %b exp 1", sticky_a); else passes++;
  endtask

  task automatic test_back_to_back();
    int nv, ne, fv, fe;
    logic [3:0] pats [4];
    pats[0] = 4'b0000; pats[1] = 4'b0011; pats[2] = 4'b1001; pats[3] = 4'b0110;
    reset_with(pats[0], 4'b0101);
    for (int s = 0; s < 4; s++) begin
      pat_a = pats[s];
      run(1'b0, 6, nv, ne, fv, fe);
      checks++; if (nv !== 1 || fv !== 5) $display("FAIL b2b_valid sym %0d got n=%0d at %0d exp n=1 at 5", s, nv, fv); else passes++;
      checks++; if (num_a !== 32'(s)) $display("FAIL b2b_num got %0d exp %0d", num_a, s); else passes++;
    end
    checks++; if (cnt_a !== 8'd4) $display("FAIL b2b_cnt got %0d exp 4", cnt_a); else passes++;
  endtask

  task automatic test_reset_mid_settle();
    int nv, ne, fv, fe;
    reset_with(4'b1001, 4'b0101);
    run(1'b0, 4, nv, ne, fv, fe);
    checks++; if (nv !== 0) $display("FAIL midrst_pre_nvalid got %0d exp 0", nv); else passes++;
    rst_n = 1'b0;
    tick();
    checks++; if (valid_a !== 1'b0 || err_a !== 1'b0) $display("FAIL midrst_pulse got v=%b e=%b exp 0 0", valid_a, err_a); else passes++;
    checks++; if (num_a !== 32'd0 || sticky_a !== 1'b0 || cnt_a !== 8'd0) $display("FAIL midrst_outputs got num=%0d st=%b cnt=%0d exp 0", num_a, sticky_a, cnt_a); else passes++;
    rst_n = 1'b1;
    run(1'b0, 8, nv, ne, fv, fe);
    checks++; if (nv !== 1 || fv !== 5) $display("FAIL midrst_window got n=%0d at %0d exp n=1 at 5", nv, fv); else passes++;
    checks++; if (num_a !== 32'd2) $display("FAIL midrst_num got %0d exp 2", num_a); else passes++;
  endtask

  task automatic test_saturate();
    int nv, ne, fv, fe;
    int total;
    logic [3:0] seq [5];
    seq[0] = 4'b0000; seq[1] = 4'b0011; seq[2] = 4'b1001; seq[3] = 4'b0110; seq[4] = 4'b0000;
    total = 0;
    reset_with(4'b0101, seq[0]);
    for (int s = 0; s < 5; s++) begin
      pat_b = seq[s];
      run(1'b1, 6, nv, ne, fv, fe);
      total += nv;
    end
    checks++; if (total !== 5) $display("FAIL sat_nvalid got %0d exp 5", total); else passes++;
    checks++; if (cnt_b !== 2'd3) $display("FAIL sat_cnt got %0d exp 3", cnt_b); else passes++;
    pat_b = 4'b0011;
    run(1'b1, 4, nv, ne, fv, fe);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    checks++; if (valid_b !== 1'b1) $display("FAIL clr_valid_pulse got %b exp 1", valid_b); else passes++;
    checks++; if (cnt_b !== 2'd1) $display("FAIL clr_valid_cnt got %0d exp 1", cnt_b); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch_then_illegal();
    test_clr_with_err();
    test_back_to_back();
    test_reset_mid_settle();
    test_saturate();
    checks++; if (both_cnt !== 0) $display("FAIL valid_err_overlap got %0d exp 0", both_cnt); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
